spi_tx_master: RTL

Parametrised SPI transmit master; successor to the fixed 16-bit SPI output stage. It accepts words over a valid/ready handshake and serialises them on SCLK/MOSI under an active-low CS. Word width, bit order, SCLK rate, SPI mode (CPOL/CPHA) and CS setup/hold/gap are set by parameters. Multi-word bursts keep CS low between words. It drives FFT result words to an external SPI sink (MCU or logic analyser).

---
 rtl/spi_tx_master_if.sv | 13 +
 rtl/spi_tx_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spi_tx_master_if.sv
// Word handshake between a data source and spi_tx_master.
// The source drives data, valid and last; the master answers with ready.
interface spi_tx_master_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_LAST;
    logic              TX_READY;

    modport master (output TX_DATA, output TX_VALID, output TX_LAST, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, input TX_LAST, output TX_READY);
endinterface

// File: rtl/spi_tx_master.sv
// Parametrised SPI transmit master: serialises handshaked words on SCLK/MOSI under an
// active-low CS, with configurable mode, bit order, SCLK rate and CS setup/hold/gap.
module spi_tx_master #(
    parameter int DATA_W    = 16,
    parameter int DIV       = 1,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_GAP    = 4
) (
    input  logic           CLK,
    input  logic           RST,
    spi_tx_master_if.slave tx,
    output logic           SCLK,
    output logic           CS,
    output logic           MOSI,
    output logic           BUSY
);

    localparam int M1    = (2 * DIV > CS_SETUP) ? 2 * DIV : CS_SETUP;
    localparam int M2    = (M1 > CS_HOLD) ? M1 : CS_HOLD;
    localparam int MAXC  = (M2 > CS_GAP) ? M2 : CS_GAP;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF       = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [DATA_W-1:0] shreg_q, shreg_n;
    logic              last_q, last_n;
    logic              sclk_q, sclk_n;
    logic              cs_q, cs_n;
    logic              mosi_q, mosi_n;
    logic              ready_q, ready_n;
    logic              busy_q, busy_n;
    logic              xfer;
    logic              out_bit;

    // Every output is registered: it is the value the next state implies.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            sclk_q  <= CPOL;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            last_q  <= last_n;
            sclk_q  <= sclk_n;
            cs_q    <= cs_n;
            mosi_q  <= mosi_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        last_n  = last_q;
        xfer    = tx.TX_VALID && ready_q;

        unique case (state_q)
            IDLE, WAIT: begin
                if (xfer) begin
                    shreg_n = tx.TX_DATA;
                    last_n  = tx.TX_LAST;
                    cnt_n   = '0;
                    bit_n   = '0;
                    // Burst words skip CS setup because CS is already low.
                    if (state_q == IDLE && CS_SETUP > 0) state_n = SETUP;
                    else                                 state_n = SHIFT;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == PER_LAST) begin
                    cnt_n = '0;
                    if (bit_q == BIT_LAST) begin
                        if (!last_q)      state_n = WAIT;
                        else if (CS_HOLD > 0) state_n = HOLD;
                        else if (CS_GAP > 0)  state_n = GAP;
                        else                  state_n = IDLE;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shreg_n = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = (CS_GAP > 0) ? GAP : IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        cs_n    = !(state_n inside {SETUP, SHIFT, WAIT, HOLD});
        ready_n = state_n inside {IDLE, WAIT};
        busy_n  = (state_n != IDLE);

        // CPHA=0 toggles SCLK mid-period; CPHA=1 toggles it at the period start.
        sclk_n = CPOL;
        if (state_n == SHIFT) begin
            if (CPHA) sclk_n = (cnt_n < HALF) ? ~CPOL : CPOL;
            else      sclk_n = (cnt_n < HALF) ? CPOL : ~CPOL;
        end

        out_bit = MSB_FIRST ? shreg_n[DATA_W-1] : shreg_n[0];
        mosi_n  = mosi_q;
        if (state_n == SHIFT || (state_n == SETUP && !CPHA)) mosi_n = out_bit;
    end

    assign SCLK        = sclk_q;
    assign CS          = cs_q;
    assign MOSI        = mosi_q;
    assign BUSY        = busy_q;
    assign tx.TX_READY = ready_q;

endmodule
